// File: rtl/ddram_arb.sv
// Two-port byte arbiter onto a 64-bit DDRAM bus. Each port keeps a one-word
// read cache; misses and writes are serialised through a single FSM.
module ddram_arb #(
  parameter logic [28:0] A_BASE = 29'h0300000,
  parameter logic [28:0] B_BASE = 29'h0400000
) (
  input  logic        clk_mem,
  input  logic        reset,
  input  logic [21:0] a_addr,
  input  logic [7:0]  a_din,
  input  logic        a_rd,
  input  logic        a_wr,
  output logic [7:0]  a_dout,
  output logic        a_ready,
  input  logic [24:0] b_addr,
  input  logic [7:0]  b_din,
  input  logic        b_rd,
  input  logic        b_wr,
  output logic [7:0]  b_dout,
  output logic        b_ready,
  input  logic        DDRAM_BUSY,
  input  logic [63:0] DDRAM_DOUT,
  input  logic        DDRAM_DOUT_READY,
  output logic [28:0] DDRAM_ADDR,
  output logic [7:0]  DDRAM_BURSTCNT,
  output logic        DDRAM_RD,
  output logic        DDRAM_WE,
  output logic [63:0] DDRAM_DIN,
  output logic [7:0]  DDRAM_BE,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT_RD = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Index 0 is port A, index 1 is port B throughout.
  logic [1:0]        lvl_w, edge_w, cap_w, hit_w, wr_w;
  logic [1:0][28:0]  word_w;
  logic [1:0][2:0]   lane_w;
  logic [1:0][7:0]   din_w;

  logic [1:0]        prev_q, ready_q, pend_q, wr_q, valid_q;
  logic [1:0][7:0]   dout_q, wdat_q;
  logic [1:0][28:0]  word_q, tag_q;
  logic [1:0][2:0]   lane_q;
  logic [1:0][63:0]  cache_q;

  logic              gnt_q, gnt_d, prio_q;
  logic              start_w, wr_done_w, rd_done_w;

  logic [28:0]       ddr_addr_q;
  logic [63:0]       ddr_din_q;
  logic [7:0]        ddr_be_q;
  logic              ddr_rd_q, ddr_we_q;

  always_comb begin
    lvl_w     = {b_rd | b_wr, a_rd | a_wr};
    edge_w    = lvl_w & ~prev_q;
    cap_w     = edge_w & ready_q;
    wr_w      = {b_wr, a_wr};
    word_w[0] = A_BASE + {10'd0, a_addr[21:3]};
    word_w[1] = B_BASE + {7'd0, b_addr[24:3]};
    lane_w[0] = a_addr[2:0];
    lane_w[1] = b_addr[2:0];
    din_w[0]  = a_din;
    din_w[1]  = b_din;
    hit_w     = '0;
    for (int i = 0; i < 2; i++) begin
      hit_w[i] = ~wr_w[i] & valid_q[i] & (tag_q[i] == word_w[i]);
    end
  end

  // Priority only flips on a contested grant, so a waiting port loses at most once.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    start_w   = 1'b0;
    wr_done_w = 1'b0;
    rd_done_w = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|pend_q) begin
          start_w = 1'b1;
          state_d = S_ISSUE;
          gnt_d   = (&pend_q) ? prio_q : pend_q[1];
        end
      end
      S_ISSUE: begin
        if (!DDRAM_BUSY) begin
          if (wr_q[gnt_q]) begin
            wr_done_w = 1'b1;
            state_d   = S_IDLE;
          end else begin
            state_d = S_WAIT_RD;
          end
        end
      end
      S_WAIT_RD: begin
        if (DDRAM_DOUT_READY) begin
          rd_done_w = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_mem or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_mem or posedge reset) begin
    if (reset) begin
      gnt_q      <= 1'b0;
      prio_q     <= 1'b0;
      ddr_addr_q <= '0;
      ddr_din_q  <= '0;
      ddr_be_q   <= '0;
      ddr_rd_q   <= 1'b0;
      ddr_we_q   <= 1'b0;
    end else begin
      if (start_w) begin
        gnt_q      <= gnt_d;
        if (&pend_q) prio_q <= ~gnt_d;
        ddr_addr_q <= word_q[gnt_d];
        ddr_din_q  <= {8{wdat_q[gnt_d]}};
        ddr_be_q   <= wr_q[gnt_d] ? (8'd1 << lane_q[gnt_d]) : 8'hFF;
        ddr_rd_q   <= ~wr_q[gnt_d];
        ddr_we_q   <= wr_q[gnt_d];
      end
      if (state_q == S_ISSUE && !DDRAM_BUSY) begin
        ddr_rd_q <= 1'b0;
        ddr_we_q <= 1'b0;
      end
    end
  end

  // Resetting prev_q high means a level already asserted at release is not a request.
  always_ff @(posedge clk_mem or posedge reset) begin
    if (reset) begin
      prev_q  <= 2'b11;
      ready_q <= 2'b11;
      pend_q  <= '0;
      wr_q    <= '0;
      valid_q <= '0;
      dout_q  <= '0;
      wdat_q  <= '0;
      word_q  <= '0;
      tag_q   <= '0;
      lane_q  <= '0;
      cache_q <= '0;
    end else begin
      prev_q <= lvl_w;
      for (int i = 0; i < 2; i++) begin
        if (cap_w[i]) begin
          word_q[i] <= word_w[i];
          lane_q[i] <= lane_w[i];
          wdat_q[i] <= din_w[i];
          wr_q[i]   <= wr_w[i];
          if (hit_w[i]) begin
            dout_q[i] <= cache_q[i][{lane_w[i], 3'b000} +: 8];
          end else begin
            ready_q[i] <= 1'b0;
            pend_q[i]  <= 1'b1;
          end
        end
        if (wr_done_w) begin
          if (int'(gnt_q) == i) begin
            ready_q[i] <= 1'b1;
            pend_q[i]  <= 1'b0;
            if (valid_q[i] && tag_q[i] == word_q[i]) begin
              cache_q[i][{lane_q[i], 3'b000} +: 8] <= wdat_q[i];
            end
          end else if (valid_q[i] && tag_q[i] == word_q[gnt_q]) begin
            valid_q[i] <= 1'b0;
          end
        end
        if (rd_done_w && int'(gnt_q) == i) begin
          cache_q[i] <= DDRAM_DOUT;
          tag_q[i]   <= word_q[i];
          valid_q[i] <= 1'b1;
          dout_q[i]  <= DDRAM_DOUT[{lane_q[i], 3'b000} +: 8];
          ready_q[i] <= 1'b1;
          pend_q[i]  <= 1'b0;
        end
      end
    end
  end

  assign a_dout         = dout_q[0];
  assign b_dout         = dout_q[1];
  assign a_ready        = ready_q[0];
  assign b_ready        = ready_q[1];
  assign DDRAM_ADDR     = ddr_addr_q;
  assign DDRAM_BURSTCNT = 8'd1;
  assign DDRAM_RD       = ddr_rd_q;
  assign DDRAM_WE       = ddr_we_q;
  assign DDRAM_DIN      = ddr_din_q;
  assign DDRAM_BE       = ddr_be_q;
  assign dbg_state_o    = state_q;

endmodule
